// File: rtl/dcache_line.sv
// rtl/dcache_line.sv - single-line write-back data cache with burst refill and dirty eviction
`timescale 1ns/1ps

module dcache_line #(
    parameter int ADDRBITS      = 32,
    parameter int DATABITS      = 32,
    parameter int BANKNUM       = 4,
    parameter int CACHEWORDS    = 32,
    parameter int CACHEADDRBITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDRBITS-1:0] dcache_addr,
    input  logic [DATABITS-1:0] dcache_datain,
    input  logic                dcache_rdreq,
    input  logic                dcache_wrreq,
    input  logic [BANKNUM-1:0]  dcache_be,
    input  logic                line_fill,
    output logic [DATABITS-1:0] line_out,
    output logic                line_valid,
    output logic                line_miss,
    input  logic [DATABITS-1:0] mem_out,
    input  logic [15:0]         mem_burstlen,
    input  logic                mem_valid,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic                mem_rdreq,
    output logic                mem_wrreq
);

    localparam int TAGBITS = ADDRBITS - CACHEADDRBITS - 2;
    localparam int CNTW    = CACHEADDRBITS + 1;
    localparam int LANEW   = DATABITS / BANKNUM;
    localparam logic [CACHEADDRBITS-1:0] LAST_WORD = CACHEADDRBITS'(CACHEWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_READREQ,
        S_FILL
    } state_t;

    state_t                   state_q, state_d;
    logic [DATABITS-1:0]      data_q [CACHEWORDS];
    logic [TAGBITS-1:0]       tag_q, tag_d;
    logic [TAGBITS-1:0]       new_tag_q, new_tag_d;
    logic                     valid_q, valid_d;
    logic                     dirty_q, dirty_d;
    logic [CACHEADDRBITS-1:0] fill_cnt_q, fill_cnt_d;
    logic [CACHEADDRBITS-1:0] wb_cnt_q, wb_cnt_d;
    logic [CNTW-1:0]          burst_cnt_q, burst_cnt_d;

    logic [DATABITS-1:0]      line_out_d;
    logic                     line_valid_d, line_miss_d;
    logic [ADDRBITS-1:0]      mem_addr_d;
    logic                     mem_rdreq_d, mem_wrreq_d;

    logic                     arr_we;
    logic [CACHEADDRBITS-1:0] arr_idx;
    logic [DATABITS-1:0]      arr_wdata;

    logic [TAGBITS-1:0]       addr_tag;
    logic [CACHEADDRBITS-1:0] addr_word;
    logic                     hit;
    logic [DATABITS-1:0]      merged;
    logic [CNTW-1:0]          eff_burst;
    logic                     unused_byte_offset;

    assign addr_tag           = dcache_addr[ADDRBITS-1 -: TAGBITS];
    assign addr_word          = dcache_addr[CACHEADDRBITS+1:2];
    assign hit                = valid_q && (tag_q == addr_tag);
    assign unused_byte_offset = ^dcache_addr[1:0];

    always_comb begin
        merged = data_q[addr_word];
        for (int i = 0; i < BANKNUM; i++) begin
            if (dcache_be[i]) begin
                merged[i*LANEW +: LANEW] = dcache_datain[i*LANEW +: LANEW];
            end
        end
    end

    // Out-of-range burst lengths fall back to a whole-line burst.
    always_comb begin
        if (mem_burstlen == 16'd0 || mem_burstlen > 16'(CACHEWORDS)) begin
            eff_burst = CNTW'(CACHEWORDS);
        end else begin
            eff_burst = mem_burstlen[CNTW-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        new_tag_d    = new_tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        fill_cnt_d   = fill_cnt_q;
        wb_cnt_d     = wb_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        line_out_d   = line_out;
        line_valid_d = 1'b0;
        line_miss_d  = 1'b0;
        mem_addr_d   = mem_addr;
        mem_rdreq_d  = 1'b0;
        mem_wrreq_d  = 1'b0;
        arr_we       = 1'b0;
        arr_idx      = addr_word;
        arr_wdata    = merged;

        if (state_q != S_IDLE && (dcache_rdreq || dcache_wrreq)) begin
            line_miss_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (dcache_wrreq) begin
                    if (hit) begin
                        arr_we       = 1'b1;
                        line_valid_d = 1'b1;
                        line_out_d   = merged;
                        dirty_d      = 1'b1;
                    end else begin
                        line_miss_d = 1'b1;
                    end
                end else if (dcache_rdreq) begin
                    if (hit) begin
                        line_valid_d = 1'b1;
                        line_out_d   = data_q[addr_word];
                    end else begin
                        line_miss_d = 1'b1;
                    end
                end
                if (line_fill) begin
                    new_tag_d  = addr_tag;
                    fill_cnt_d = '0;
                    wb_cnt_d   = '0;
                    // A write hit in the same cycle makes the line dirty too.
                    if (valid_q && (dirty_q || (dcache_wrreq && hit))) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_READREQ;
                    end
                end
            end
            S_WRITEBACK: begin
                mem_wrreq_d = 1'b1;
                mem_addr_d  = {tag_q, wb_cnt_q, 2'b00};
                line_out_d  = data_q[wb_cnt_q];
                wb_cnt_d    = wb_cnt_q + CACHEADDRBITS'(1);
                if (wb_cnt_q == LAST_WORD) begin
                    dirty_d = 1'b0;
                    state_d = S_READREQ;
                end
            end
            S_READREQ: begin
                mem_rdreq_d = 1'b1;
                mem_addr_d  = {new_tag_q, fill_cnt_q, 2'b00};
                valid_d     = 1'b0;
                burst_cnt_d = '0;
                state_d     = S_FILL;
            end
            S_FILL: begin
                if (mem_valid) begin
                    arr_we      = 1'b1;
                    arr_idx     = fill_cnt_q;
                    arr_wdata   = mem_out;
                    fill_cnt_d  = fill_cnt_q + CACHEADDRBITS'(1);
                    burst_cnt_d = burst_cnt_q + CNTW'(1);
                    if (fill_cnt_q == LAST_WORD) begin
                        tag_d   = new_tag_q;
                        valid_d = 1'b1;
                        dirty_d = 1'b0;
                        state_d = S_IDLE;
                    end else if ((burst_cnt_q + CNTW'(1)) >= eff_burst) begin
                        state_d = S_READREQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tag_q       <= '0;
            new_tag_q   <= '0;
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            fill_cnt_q  <= '0;
            wb_cnt_q    <= '0;
            burst_cnt_q <= '0;
            line_out    <= '0;
            line_valid  <= 1'b0;
            line_miss   <= 1'b0;
            mem_addr    <= '0;
            mem_rdreq   <= 1'b0;
            mem_wrreq   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            new_tag_q   <= new_tag_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            fill_cnt_q  <= fill_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            line_out    <= line_out_d;
            line_valid  <= line_valid_d;
            line_miss   <= line_miss_d;
            mem_addr    <= mem_addr_d;
            mem_rdreq   <= mem_rdreq_d;
            mem_wrreq   <= mem_wrreq_d;
        end
    end

    // Data array has no reset; its contents are meaningless until a fill completes.
    always_ff @(posedge clk) begin
        if (!reset && arr_we) begin
            data_q[arr_idx] <= arr_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_line.sv
// tb/tb_dcache_line.sv - scoreboard bench for dcache_line
`timescale 1ns/1ps

module tb_dcache_line;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dcache_addr, dcache_datain;
    logic        dcache_rdreq, dcache_wrreq;
    logic [3:0]  dcache_be;
    logic        line_fill;
    logic [31:0] line_out;
    logic        line_valid, line_miss;
    logic [31:0] mem_out;
    logic [15:0] mem_burstlen;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_rdreq, mem_wrreq;

    dcache_line dut (
        .clk(clk), .reset(reset),
        .dcache_addr(dcache_addr), .dcache_datain(dcache_datain),
        .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
        .dcache_be(dcache_be), .line_fill(line_fill),
        .line_out(line_out), .line_valid(line_valid), .line_miss(line_miss),
        .mem_out(mem_out), .mem_burstlen(mem_burstlen), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [32:0] cpu_q [$];   // {miss, data}
    logic [64:0] mem_q [$];   // {is_write, addr, data}

    bit          b_valid, b_dirty;
    logic [24:0] b_tag;
    logic [31:0] b_line [32];
    logic [31:0] fill_word [32];

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] ce;
        logic [64:0] me;
        if (reset === 1'b0) begin
            check("hygiene", {63'b0, line_valid && line_miss, mem_rdreq && mem_wrreq}, 65'b0);
            if (line_valid || line_miss) begin
                compared++;
                assert (cpu_q.size() > 0) else begin
                    mismatched++;
                    $error("FAIL cpu_unexpected: observed valid=%b miss=%b expected no response", line_valid, line_miss);
                end
                if (cpu_q.size() > 0) begin
                    ce = cpu_q.pop_front();
                    check("cpu_resp", {32'b0, line_miss, line_miss ? 32'b0 : line_out}, {32'b0, ce});
                end
            end
            if (mem_rdreq || mem_wrreq) begin
                compared++;
                assert (mem_q.size() > 0) else begin
                    mismatched++;
                    $error("FAIL mem_unexpected: observed rd=%b wr=%b addr=%h expected no traffic", mem_rdreq, mem_wrreq, mem_addr);
                end
                if (mem_q.size() > 0) begin
                    me = mem_q.pop_front();
                    check("mem_access", {mem_wrreq, mem_addr, mem_wrreq ? line_out : 32'b0}, me);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b, input bit busy);
        logic [4:0]  idx;
        logic [31:0] m;
        bit          hit;
        idx = a[6:2];
        hit = !busy && b_valid && (b_tag == a[31:7]);
        if (!hit) begin
            cpu_q.push_back({1'b1, 32'b0});
        end else if (wr) begin
            m = b_line[idx];
            for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = d[8*i +: 8];
            b_line[idx] = m;
            b_dirty = 1'b1;
            cpu_q.push_back({1'b0, m});
        end else begin
            cpu_q.push_back({1'b0, b_line[idx]});
        end
        @(posedge clk); #1;
        dcache_rdreq = rd; dcache_wrreq = wr; dcache_addr = a; dcache_datain = d; dcache_be = b;
        @(posedge clk); #1;
        dcache_rdreq = 1'b0; dcache_wrreq = 1'b0;
    endtask

    task automatic wait_rdreq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_rdreq) begin
                ok = 1'b1;
                break;
            end
        end
        compared++;
        assert (ok) else begin
            mismatched++;
            $error("FAIL rdreq_timeout: observed no mem_rdreq expected one within 300 cycles");
        end
    endtask

    task automatic mem_burst(input int first, input int n, input int gap_at);
        for (int j = 0; j < n; j++) begin
            if (j == gap_at) begin
                @(posedge clk); #1;
                mem_valid = 1'b0; mem_out = 32'hBAD0BAD0;
            end
            @(posedge clk); #1;
            mem_valid = 1'b1; mem_out = fill_word[first + j];
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a, input int blen, input int gap_at, input bit poke);
        int eb;
        bit ok;
        eb = (blen == 0 || blen > 32) ? 32 : blen;
        if (b_valid && b_dirty)
            for (int k = 0; k < 32; k++) mem_q.push_back({1'b1, b_tag, 5'(k), 2'b00, b_line[k]});
        for (int s = 0; s < 32; s += eb) mem_q.push_back({1'b0, a[31:7], 5'(s), 2'b00, 32'b0});
        mem_burstlen = 16'(blen);
        @(posedge clk); #1;
        line_fill = 1'b1; dcache_addr = a;
        @(posedge clk); #1;
        line_fill = 1'b0;
        for (int s = 0; s < 32; s += eb) begin
            wait_rdreq(ok);
            if (!ok) return;
            if (poke && s == 0) cpu_req(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1);
            mem_burst(s, (32 - s < eb) ? 32 - s : eb, (s == 0) ? gap_at : -1);
        end
        b_tag = a[31:7]; b_valid = 1'b1; b_dirty = 1'b0;
        for (int k = 0; k < 32; k++) b_line[k] = fill_word[k];
        idle(2);
    endtask

    initial begin
        bit ok;
        reset = 1'b1;
        dcache_addr = '0; dcache_datain = '0; dcache_rdreq = 0; dcache_wrreq = 0;
        dcache_be = '0; line_fill = 0; mem_out = '0; mem_burstlen = '0; mem_valid = 0;
        b_valid = 0; b_dirty = 0; b_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_line_out", {33'b0, line_out}, 65'b0);
        check("reset_strobes", {29'b0, mem_addr, line_valid, line_miss, mem_rdreq, mem_wrreq}, 65'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Cold line: both request kinds miss, no memory traffic.
        cpu_req(1, 0, 32'hD00FAFFC, 32'h0, 4'h0, 0);
        cpu_req(0, 1, 32'hD00FAFFC, 32'hDEADBEEF, 4'hF, 0);
        idle(5);

        // Clean fill with a wait cycle and a busy-time request; burstlen 0 means whole line.
        for (int i = 0; i < 32; i++)
            fill_word[i] = (i < 10) ? 32'h100 + i : (i < 13) ? 32'h110 + (i - 10) : 32'(113 + (i - 13));
        do_fill(32'hD00FAFFC, 0, 4, 1);

        cpu_req(1, 0, 32'hD00FAFFC, 32'h0, 4'h0, 0);
        cpu_req(0, 1, 32'hD00FAFFC, 32'hDEADBEEF, 4'hF, 0);
        cpu_req(1, 0, 32'hD00FAFFC, 32'h0, 4'h0, 0);
        cpu_req(1, 1, 32'hD00FAF84, 32'h11223344, 4'b0110, 0);
        cpu_req(1, 0, 32'hD00FAF84, 32'h0, 4'h0, 0);

        // Memory data outside a fill must not reach the array.
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_out = 32'hFFFFFFFF;
        idle(3);
        mem_valid = 1'b0;
        cpu_req(1, 0, 32'hD00FAF94, 32'h0, 4'h0, 0);

        // Dirty eviction, burstlen above line size.
        cpu_req(1, 0, 32'hCCCCCCCC, 32'h0, 4'h0, 0);
        for (int i = 0; i < 32; i++)
            fill_word[i] = (i < 19) ? 32'h200 + i : 32'(213 + (i - 19));
        do_fill(32'hCCCCCCCC, 40, -1, 0);
        cpu_req(1, 0, 32'hCCCCCCCC, 32'h0, 4'h0, 0);

        // Byte-lane merge.
        cpu_req(0, 1, 32'hCCCCCCCC, 32'hDEADBEEF, 4'hF, 0);
        cpu_req(0, 1, 32'hCCCCCCCC, 32'hAABBCCDD, 4'b0001, 0);
        cpu_req(1, 0, 32'hCCCCCCCC, 32'h0, 4'h0, 0);

        // Multi-burst refill after another eviction.
        for (int i = 0; i < 32; i++) fill_word[i] = $urandom;
        do_fill(32'h12345678, 8, -1, 0);
        cpu_req(1, 0, 32'h12345678, 32'h0, 4'h0, 0);
        cpu_req(1, 0, 32'h12345600, 32'h0, 4'h0, 0);
        cpu_req(1, 0, 32'h12345644, 32'h0, 4'h0, 0);

        // Reset in the middle of a fill leaves the line invalid and the bus quiet.
        for (int i = 0; i < 32; i++) fill_word[i] = $urandom;
        mem_q.push_back({1'b0, 25'(32'h0BADF00C >> 7), 7'b0, 32'b0});
        mem_burstlen = 16'd32;
        @(posedge clk); #1;
        line_fill = 1'b1; dcache_addr = 32'h0BADF00C;
        @(posedge clk); #1;
        line_fill = 1'b0;
        wait_rdreq(ok);
        mem_burst(0, 5, -1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        b_valid = 1'b0; b_dirty = 1'b0;
        cpu_req(1, 0, 32'h0BADF00C, 32'h0, 4'h0, 0);
        idle(40);

        check("cpu_q_drained", 65'(cpu_q.size()), 65'b0);
        check("mem_q_drained", 65'(mem_q.size()), 65'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule
